spi_block_ctrl: RTL

Sequences the byte-wide SPI master to move one 128-bit AES block (16 bytes) per request. It loads the block, issues one byte transfer at a time, and reassembles the 16 received bytes into a 128-bit result. It sits between the AES core / top-level control and the SPI master, and is the only driver of the master's start and data_in. A watchdog aborts the block if the master stalls.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_watchdog.sv | 29 ++
 rtl/spi_block_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI block sequencer and its watchdog.
package spi_pkg;

   localparam int BYTE_W     = 8;
   localparam int NBYTES_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      GAP,
      DONE
   } state_t;

endpackage

// File: rtl/spi_watchdog.sv
// Stall watchdog: cleared on byte start, counts while enabled, pulses expire
// on the cycle whose increment would reach TIMEOUT-1.
module spi_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable && (count == CW'(TIMEOUT - 2));

endmodule

// File: rtl/spi_block_ctrl.sv
// Moves one NBYTES block through the byte-wide SPI master, MSB byte first,
// reassembling the received bytes into blk_rx.
module spi_block_ctrl
   import spi_pkg::*;
#(
   parameter int NBYTES     = NBYTES_DEF,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     blk_start,
   input  logic [BYTE_W*NBYTES-1:0] blk_tx,
   output logic [BYTE_W*NBYTES-1:0] blk_rx,
   output logic                     blk_busy,
   output logic                     blk_done,
   output logic                     blk_err,
   output logic                     m_start,
   output logic [BYTE_W-1:0]        m_data_in,
   input  logic [BYTE_W-1:0]        m_data_out,
   input  logic                     m_busy,
   input  logic                     m_done
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t        state, next;
   logic [W-1:0]  tx_sr, tx_nxt, rx_sr, rx_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic          m_done_q, done_edge, wd_expire, abort;
   logic          unused_m_busy;

   assign unused_m_busy = m_busy;
   assign done_edge     = m_done & ~m_done_q;

   spi_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .reset (reset),
      .clear (state == START),
      .enable(state == WAIT),
      .expire(wd_expire)
   );

   always_comb begin
      next    = state;
      tx_nxt  = tx_sr;
      rx_nxt  = rx_sr;
      idx_nxt = idx;
      gap_nxt = gap_cnt;
      abort   = 1'b0;
      case (state)
         IDLE: begin
            if (blk_start) begin
               next    = START;
               tx_nxt  = blk_tx;
               rx_nxt  = '0;
               idx_nxt = '0;
            end
         end
         START: next = WAIT;
         WAIT: begin
            // a done edge coinciding with expiry wins: the byte is good
            if (done_edge) begin
               rx_nxt  = {rx_sr[W-BYTE_W-1:0], m_data_out};
               tx_nxt  = tx_sr << BYTE_W;
               gap_nxt = '0;
               if (idx == IW'(NBYTES - 1)) begin
                  next = DONE;
               end else begin
                  idx_nxt = idx + 1'b1;
                  next    = (GAP_CYCLES == 0) ? START : GAP;
               end
            end else if (wd_expire) begin
               next  = DONE;
               abort = 1'b1;
            end
         end
         GAP: begin
            gap_nxt = gap_cnt + 1'b1;
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
               next = START;
            end
         end
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         idx      <= '0;
         gap_cnt  <= '0;
         m_done_q <= 1'b0;
      end else begin
         state    <= next;
         tx_sr    <= tx_nxt;
         rx_sr    <= rx_nxt;
         idx      <= idx_nxt;
         gap_cnt  <= gap_nxt;
         m_done_q <= m_done;
      end
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blk_rx    <= '0;
         blk_busy  <= 1'b0;
         blk_done  <= 1'b0;
         blk_err   <= 1'b0;
         m_start   <= 1'b0;
         m_data_in <= '0;
      end else begin
         m_start  <= (next == START);
         blk_busy <= (next == START) || (next == WAIT) || (next == GAP);
         blk_done <= (next == DONE);
         blk_err  <= abort;
         if (next == START) begin
            m_data_in <= tx_nxt[W-1 -: BYTE_W];
         end
         if ((next == DONE) && !abort) begin
            blk_rx <= rx_nxt;
         end
      end
   end

endmodule
